// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions: MESI coherence state encoding and the position of
// the MESI field inside a cache-line metadata payload.
// Consumers import rvh_l1d_pkg::* to pick up the field defaults and state enum.
package rvh_l1d_pkg;

    // Default location of the MESI state bits inside an L1D payload entry.
    localparam int L1D_MESI_LSB = 14;
    localparam int L1D_MESI_W   = 2;

    typedef enum logic [L1D_MESI_W-1:0] {
        MESI_INVALID   = 2'b00,
        MESI_SHARED    = 2'b01,
        MESI_EXCLUSIVE = 2'b10,
        MESI_MODIFIED  = 2'b11
    } mesi_state_e;

endpackage

// File: rtl/usage_manager.sv
// Pointer and occupancy tracker for a multi-lane circular FIFO.
// Ports: clk/rst (sync, active-high), flush_i, per-lane enqueue/dequeue fire
// vectors in; head/tail pointers, occupancy, enqueue ready and dequeue valid out.
// Ready/valid depend only on the registered count, so no same-cycle reuse of freed slots.
module usage_manager #(
    parameter int DEPTH          = 16,
    parameter int ENQ_WIDTH      = 1,
    parameter int DEQ_WIDTH      = 1,
    parameter int MUST_TAKEN_ALL = 1,
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [ENQ_WIDTH-1:0] enq_fire_i,
    input  logic [DEQ_WIDTH-1:0] deq_fire_i,
    output logic [PTR_W-1:0]     head_o,
    output logic [PTR_W-1:0]     tail_o,
    output logic [CNT_W-1:0]     count_o,
    output logic [ENQ_WIDTH-1:0] enq_rdy_o,
    output logic [DEQ_WIDTH-1:0] deq_vld_o
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_enq_n;
    logic [CNT_W-1:0] w_deq_n;
    logic [CNT_W-1:0] w_free;

    // Fire vectors are prefix-contiguous, so the popcount is the lane count.
    assign w_enq_n = CNT_W'($countones(enq_fire_i));
    assign w_deq_n = CNT_W'($countones(deq_fire_i));
    assign w_free  = CNT_W'(DEPTH) - r_count;

    always_comb begin
        enq_rdy_o = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (MUST_TAKEN_ALL != 0) enq_rdy_o[i] = (w_free >= CNT_W'(ENQ_WIDTH));
            else                     enq_rdy_o[i] = (w_free > CNT_W'(i));
        end
    end

    always_comb begin
        deq_vld_o = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            deq_vld_o[i] = (r_count > CNT_W'(i));
        end
    end

    // DEPTH is a power of two: truncating the advance to PTR_W bits gives the
    // modulo-DEPTH wrap, including an advance of exactly DEPTH lanes.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_deq_n[PTR_W-1:0];
            r_tail  <= r_tail + w_enq_n[PTR_W-1:0];
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

    assign head_o  = r_head;
    assign tail_o  = r_tail;
    assign count_o = r_count;

endmodule

// File: rtl/mp_fifo_patch.sv
// Multi-port circular FIFO whose entries expose a patchable field (MESI state).
// Ports: clk/rst (sync, active-high), flush_i, ENQ_W enqueue lanes, DEQ_W dequeue lanes,
// patch_en/ptr/val, full storage view payload_o/payload_vld_o and occupancy count_o.
// Option macro MP_FIFO_PATCH_BYPASS_EN: dequeue lanes reflect a same-cycle patch to head slots.
module mp_fifo_patch
    import rvh_l1d_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int PAYLOAD_W      = 512,
    parameter int ENQ_W          = 1,
    parameter int DEQ_W          = 1,
    parameter int MUST_TAKEN_ALL = 1,
    parameter int FIELD_LSB      = L1D_MESI_LSB,
    parameter int FIELD_W        = L1D_MESI_W,
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [ENQ_W-1:0]           enqueue_vld_i,
    input  logic [ENQ_W*PAYLOAD_W-1:0] enqueue_payload_i,
    output logic [ENQ_W-1:0]           enqueue_rdy_o,
    output logic [DEQ_W-1:0]           dequeue_vld_o,
    output logic [DEQ_W*PAYLOAD_W-1:0] dequeue_payload_o,
    input  logic [DEQ_W-1:0]           dequeue_rdy_i,
    input  logic                       patch_en_i,
    input  logic [PTR_W-1:0]           patch_ptr_i,
    input  logic [FIELD_W-1:0]         patch_val_i,
    output logic [DEPTH*PAYLOAD_W-1:0] payload_o,
    output logic [DEPTH-1:0]           payload_vld_o,
    output logic [CNT_W-1:0]           count_o
);

    logic [PTR_W-1:0]     w_head;
    logic [PTR_W-1:0]     w_tail;
    logic [ENQ_W-1:0]     w_enq_fire;
    logic [DEQ_W-1:0]     w_deq_fire;
    logic [DEPTH-1:0]     w_enq_hit;
    logic [DEPTH-1:0]     w_deq_hit;
    logic [DEPTH-1:0]     w_patch_hit;
    logic [DEPTH-1:0]     w_wr_en;
    logic [PAYLOAD_W-1:0] w_enq_dat [DEPTH];
    logic [PAYLOAD_W-1:0] w_wr_dat  [DEPTH];
    logic [PAYLOAD_W-1:0] r_mem     [DEPTH];
    logic [DEPTH-1:0]     r_vld;

    assign w_enq_fire = enqueue_vld_i & enqueue_rdy_o;
    assign w_deq_fire = dequeue_vld_o & dequeue_rdy_i;

    usage_manager #(
        .DEPTH          (DEPTH),
        .ENQ_WIDTH      (ENQ_W),
        .DEQ_WIDTH      (DEQ_W),
        .MUST_TAKEN_ALL (MUST_TAKEN_ALL)
    ) u_usage_manager (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .enq_fire_i (w_enq_fire),
        .deq_fire_i (w_deq_fire),
        .head_o     (w_head),
        .tail_o     (w_tail),
        .count_o    (count_o),
        .enq_rdy_o  (enqueue_rdy_o),
        .deq_vld_o  (dequeue_vld_o)
    );

    // Map lane fires onto physical slots.
    always_comb begin
        w_enq_hit = '0;
        w_deq_hit = '0;
        for (int s = 0; s < DEPTH; s++) w_enq_dat[s] = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            if (w_enq_fire[i]) begin
                w_enq_hit[w_tail + PTR_W'(i)] = 1'b1;
                w_enq_dat[w_tail + PTR_W'(i)] = enqueue_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        for (int i = 0; i < DEQ_W; i++) begin
            if (w_deq_fire[i]) w_deq_hit[w_head + PTR_W'(i)] = 1'b1;
        end
    end

    // A patch lands on a resident entry that is staying, or on an entry being
    // written this cycle (the incoming payload is stored already patched).
    // rst and flush suppress every storage write this cycle.
    always_comb begin
        w_patch_hit = '0;
        w_wr_en     = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_patch_hit[s] = patch_en_i && (patch_ptr_i == PTR_W'(s)) &&
                             (w_enq_hit[s] || (r_vld[s] && !w_deq_hit[s]));
            w_wr_dat[s]    = w_enq_hit[s] ? w_enq_dat[s] : r_mem[s];
            if (w_patch_hit[s]) w_wr_dat[s][FIELD_LSB +: FIELD_W] = patch_val_i;
            w_wr_en[s]     = (w_enq_hit[s] || w_patch_hit[s]) && !rst && !flush_i;
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < DEPTH; s++) begin
            if (w_wr_en[s]) r_mem[s] <= w_wr_dat[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_vld <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (w_enq_hit[s])      r_vld[s] <= 1'b1;
                else if (w_deq_hit[s]) r_vld[s] <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [PTR_W-1:0] w_slot;
        dequeue_payload_o = '0;
        w_slot            = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            w_slot = w_head + PTR_W'(i);
            dequeue_payload_o[i*PAYLOAD_W +: PAYLOAD_W] = r_mem[w_slot];
`ifdef MP_FIFO_PATCH_BYPASS_EN
            // Forward the patch field without waiting for the storage write.
            if (patch_en_i && (patch_ptr_i == w_slot) && r_vld[w_slot])
                dequeue_payload_o[i*PAYLOAD_W + FIELD_LSB +: FIELD_W] = patch_val_i;
`endif
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_view
        assign payload_o[s*PAYLOAD_W +: PAYLOAD_W] = r_mem[s];
    end
    assign payload_vld_o = r_vld;

    // Lane vectors must be prefix-contiguous from lane 0 (v & (v+1) == 0).
    a_enq_prefix: assert property (@(posedge clk) disable iff (rst)
        ((enqueue_vld_i & (enqueue_vld_i + ENQ_W'(1))) == '0));
    a_deq_prefix: assert property (@(posedge clk) disable iff (rst)
        ((dequeue_rdy_i & (dequeue_rdy_i + DEQ_W'(1))) == '0));

endmodule

// File: tb/tb_mp_fifo_patch.sv
module tb_mp_fifo_patch;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  enq_vld;
    logic [31:0] enq_pay;
    logic [1:0]  deq_rdy;
    logic        patch_en;
    logic [1:0]  patch_ptr;
    logic [1:0]  patch_val;

    logic [1:0]  enq_rdy,  u1_enq_rdy;
    logic [1:0]  deq_vld,  u1_deq_vld;
    logic [31:0] deq_pay,  u1_deq_pay;
    logic [63:0] pay_all,  u1_pay_all;
    logic [3:0]  pvld,     u1_pvld;
    logic [2:0]  count,    u1_count;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] q[$];

    mp_fifo_patch #(
        .DEPTH(4), .PAYLOAD_W(16), .ENQ_W(2), .DEQ_W(2),
        .MUST_TAKEN_ALL(1), .FIELD_LSB(14), .FIELD_W(2)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .enqueue_vld_i(enq_vld), .enqueue_payload_i(enq_pay), .enqueue_rdy_o(enq_rdy),
        .dequeue_vld_o(deq_vld), .dequeue_payload_o(deq_pay), .dequeue_rdy_i(deq_rdy),
        .patch_en_i(patch_en), .patch_ptr_i(patch_ptr), .patch_val_i(patch_val),
        .payload_o(pay_all), .payload_vld_o(pvld), .count_o(count)
    );

    mp_fifo_patch #(
        .DEPTH(4), .PAYLOAD_W(16), .ENQ_W(2), .DEQ_W(2),
        .MUST_TAKEN_ALL(0), .FIELD_LSB(14), .FIELD_W(2)
    ) dut_partial (
        .clk(clk), .rst(rst), .flush_i(flush),
        .enqueue_vld_i(enq_vld), .enqueue_payload_i(enq_pay), .enqueue_rdy_o(u1_enq_rdy),
        .dequeue_vld_o(u1_deq_vld), .dequeue_payload_o(u1_deq_pay), .dequeue_rdy_i(deq_rdy),
        .patch_en_i(patch_en), .patch_ptr_i(patch_ptr), .patch_val_i(patch_val),
        .payload_o(u1_pay_all), .payload_vld_o(u1_pvld), .count_o(u1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] slot(input int s);
        return pay_all[s*16 +: 16];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; enq_vld = '0; enq_pay = '0; deq_rdy = '0;
        patch_en = 1'b0; patch_ptr = '0; patch_val = '0;
    endtask

    // Scoreboard monitor: every fired dequeue lane pops the next expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (deq_vld[i] && deq_rdy[i]) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL deq_unexpected lane %0d: got %0h expected none", i, deq_pay[i*16 +: 16]);
                    end else begin
                        chk($sformatf("deq_lane%0d", i), 64'(deq_pay[i*16 +: 16]), 64'(q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_count", 64'(count), 0);
        chk("rst_enq_rdy", 64'(enq_rdy), 2'b11);
        chk("rst_deq_vld", 64'(deq_vld), 0);
        chk("rst_pvld", 64'(pvld), 0);

        // Fill 1,2 then 3,4
        enq_vld = 2'b11; enq_pay = {16'h0002, 16'h0001};
        q.push_back(16'h0001); q.push_back(16'h0002);
        @(negedge clk);
        chk("no_empty_bypass", 64'(deq_vld), 0);
        cyc(); idle();
        enq_vld = 2'b11; enq_pay = {16'h0004, 16'h0003};
        q.push_back(16'h0003); q.push_back(16'h0004);
        cyc(); idle();
        chk("full_count", 64'(count), 4);
        chk("full_enq_rdy", 64'(enq_rdy), 2'b00);
        chk("full_pvld", 64'(pvld), 4'b1111);

        // Dequeue two (1,2 via scoreboard)
        deq_rdy = 2'b11;
        cyc(); idle();
        chk("deq2_count", 64'(count), 2);
        chk("deq2_enq_rdy", 64'(enq_rdy), 2'b11);
        chk("deq2_pvld", 64'(pvld), 4'b1100);

        // Wrap enqueue of 5 into slot 0
        enq_vld = 2'b01; enq_pay = {16'h0000, 16'h0005};
        q.push_back(16'h0005);
        cyc(); idle();
        chk("wrap_slot0", 64'(slot(0)), 16'h0005);
        chk("cnt3_count", 64'(count), 3);
        chk("cnt3_rdy_all", 64'(enq_rdy), 2'b00);
        chk("cnt3_rdy_partial", 64'(u1_enq_rdy), 2'b01);
        chk("cnt3_pvld", 64'(pvld), 4'b1101);

        // Patch an invalid slot: ignored
        patch_en = 1'b1; patch_ptr = 2'd1; patch_val = 2'b11;
        cyc(); idle();
        chk("patch_invalid_slot1", 64'(slot(1)), 16'h0002);
        chk("patch_invalid_pvld", 64'(pvld), 4'b1101);

        // Dequeue 3,4 while patching head slot 2: patch dropped
        deq_rdy = 2'b11; patch_en = 1'b1; patch_ptr = 2'd2; patch_val = 2'b11;
        cyc(); idle();
        chk("patch_deq_dropped", 64'(slot(2)), 16'h0003);
        chk("deq_patch_count", 64'(count), 1);
        chk("deq_patch_pvld", 64'(pvld), 4'b0001);

        // Enqueue 0x0002 (slot1), 0x3FFF (slot2) with patch 2'b10 on slot 2
        enq_vld = 2'b11; enq_pay = {16'h3FFF, 16'h0002};
        patch_en = 1'b1; patch_ptr = 2'd2; patch_val = 2'b10;
        q.push_back(16'h0002); q.push_back(16'hBFFF);
        cyc(); idle();
        chk("patch_on_enq_slot2", 64'(slot(2)), 16'hBFFF);
        chk("enq_slot1", 64'(slot(1)), 16'h0002);
        chk("patch_enq_pvld", 64'(pvld), 4'b0111);

        // Patch valid slot 1 holding 0x0002 with 2'b11
        patch_en = 1'b1; patch_ptr = 2'd1; patch_val = 2'b11;
        q[1] = 16'hC002;
        cyc(); idle();
        chk("patch_valid_slot1", 64'(slot(1)), 16'hC002);
        chk("patch_valid_count", 64'(count), 3);

        // Drain and refill across the wrap
        deq_rdy = 2'b01;
        cyc(); idle();
        enq_vld = 2'b01; enq_pay = {16'h0000, 16'h0006};
        q.push_back(16'h0006);
        cyc(); idle();
        deq_rdy = 2'b11;
        cyc(); idle();
        enq_vld = 2'b11; enq_pay = {16'h0008, 16'h0007};
        q.push_back(16'h0007); q.push_back(16'h0008);
        cyc(); idle();
        chk("refill_count", 64'(count), 3);
        chk("refill_pvld", 64'(pvld), 4'b1011);

        // Flush with same-cycle enqueue and patch
        flush = 1'b1; enq_vld = 2'b11; enq_pay = {16'hBBBB, 16'hAAAA};
        patch_en = 1'b1; patch_ptr = 2'd0; patch_val = 2'b11;
        cyc(); idle();
        q.delete();
        chk("flush_count", 64'(count), 0);
        chk("flush_pvld", 64'(pvld), 0);
        chk("flush_deq_vld", 64'(deq_vld), 0);
        chk("flush_count_partial", 64'(u1_count), 0);
        chk("flush_storage_kept", 64'(slot(0)), 16'h0007);

        // Pointers restart at slot 0 after flush
        enq_vld = 2'b11; enq_pay = {16'h000A, 16'h0009};
        q.push_back(16'h0009); q.push_back(16'h000A);
        cyc(); idle();
        chk("post_flush_slot0", 64'(slot(0)), 16'h0009);
        chk("post_flush_slot1", 64'(slot(1)), 16'h000A);
        deq_rdy = 2'b01;
        cyc(); idle();

        // Reset mid-operation beats flush, fires and patches
        rst = 1'b1; flush = 1'b1; enq_vld = 2'b11; enq_pay = {16'h2222, 16'h1111};
        patch_en = 1'b1; patch_ptr = 2'd1; patch_val = 2'b11;
        cyc(); idle();
        rst = 1'b0;
        q.delete();
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_pvld", 64'(pvld), 0);
        chk("mid_rst_deq_vld", 64'(deq_vld), 0);
        chk("mid_rst_enq_rdy", 64'(enq_rdy), 2'b11);
        chk("mid_rst_enq_discard", 64'(slot(2)), 16'hBFFF);
        chk("mid_rst_patch_discard", 64'(slot(1)), 16'h000A);

        repeat (3) cyc();
        chk("scoreboard_empty", 64'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mp_fifo_patch.md
MP_FIFO_PATCH -- requirements
Module: mp_fifo_patch

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count, power of two, >=2.
REQ-002 SHALL have parameter PAYLOAD_W, default 512: bits per entry.
REQ-003 SHALL have parameter ENQ_W, default 1: enqueue lanes, 1..DEPTH.
REQ-004 SHALL have parameter DEQ_W, default 1: dequeue lanes, 1..DEPTH.
REQ-005 SHALL have parameter MUST_TAKEN_ALL, default 1: enqueue is all-or-nothing.
REQ-006 SHALL have parameters FIELD_LSB, default 14, and FIELD_W, default 2: the patchable field (MESI state); FIELD_LSB+FIELD_W <= PAYLOAD_W.
REQ-007 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); reset rst, synchronous, active-high; clock clk.
REQ-008 SHALL have flush_i (in, 1): drop all entries.
REQ-009 SHALL have enqueue_vld_i (in, ENQ_W), enqueue_payload_i (in, ENQ_W*PAYLOAD_W) and enqueue_rdy_o (out, ENQ_W).
REQ-010 SHALL have dequeue_vld_o (out, DEQ_W), dequeue_payload_o (out, DEQ_W*PAYLOAD_W) and dequeue_rdy_i (in, DEQ_W).
REQ-011 SHALL have patch_en_i (in, 1), patch_ptr_i (in, clog2(DEPTH)) and patch_val_i (in, FIELD_W).
REQ-012 SHALL have payload_o (out, DEPTH*PAYLOAD_W), payload_vld_o (out, DEPTH) and count_o (out, clog2(DEPTH+1)): occupancy.

Function
REQ-013 SHALL operate as a circular FIFO with head/tail pointers that wrap modulo DEPTH; lane i uses slot (ptr+i) mod DEPTH.
REQ-014 SHALL compute enqueue ready from registered free space only; with MUST_TAKEN_ALL=1, all enqueue_rdy_o bits = (free >= ENQ_W); otherwise enqueue_rdy_o[i] = (free > i).
REQ-015 SHALL set dequeue_vld_o[i] = (count > i); dequeue_payload_o lane i = entry at head+i.
REQ-016 SHALL count a lane as fired when vld & rdy on that lane; valid/ready vectors are prefix-contiguous from lane 0, and non-prefix patterns are illegal (assertion).
REQ-017 SHALL update count_o by +enq_fires - deq_fires each cycle; simultaneous enqueue and dequeue are legal at any occupancy, and space freed by a dequeue is not reusable until the next cycle.
REQ-018 SHALL make an enqueued entry visible on dequeue no earlier than the cycle after enqueue, with no empty-bypass path.
REQ-019 SHALL set payload_vld_o[slot] on enqueue and clear it on dequeue, with at most one event per slot per cycle.
REQ-020 SHALL, on patch_en_i with payload_vld_o[patch_ptr_i]=1, write patch_val_i into bits [FIELD_LSB+:FIELD_W] of that entry at the clock edge; other bits are unchanged.
REQ-021 SHALL ignore a patch to a slot that is invalid or being dequeued in the same cycle.
REQ-022 SHALL, on a patch to a slot being enqueued in the same cycle, store the enqueue payload with the field replaced by patch_val_i.
REQ-023 SHALL, on flush_i, next cycle set count=0, pointers=0 and payload_vld_o=0; flush overrides same-cycle fires and patches; payload storage is retained.

Reset
REQ-024 SHALL clear pointers, count_o, payload_vld_o and dequeue_vld_o on rst; payload storage is not reset.
REQ-025 SHALL, when rst is asserted mid-operation, discard all in-flight fires and patches, with rst taking priority over flush_i.

Configuration
REQ-026 SHALL provide macro MP_FIFO_PATCH_BYPASS_EN: when defined, dequeue_payload_o lanes combinationally reflect a same-cycle valid patch to the head slots; when undefined, a patch is visible on outputs the cycle after.

Structure
REQ-027 SHALL place FIELD_LSB/FIELD_W defaults (MESI field position) and the MESI state enum in the shared rvh_l1d_pkg.
REQ-028 SHALL place pointer/count arithmetic in the sub-module usage_manager, parameterised with ENQ_WIDTH=ENQ_W and DEQ_WIDTH=DEQ_W; storage and patch logic stay in mp_fifo_patch.

Verification (DEPTH=4, PAYLOAD_W=16, ENQ_W=2, DEQ_W=2, FIELD_LSB=14, FIELD_W=2)
REQ-029 SHALL cover: after reset -> count_o=0, enqueue_rdy_o=2'b11, dequeue_vld_o=0, payload_vld_o=0.
REQ-030 SHALL cover: enqueue 0x0001/0x0002 then 0x0003/0x0004 -> count_o=4, enqueue_rdy_o=0; dequeue 2 -> 0x0001,0x0002; wrap enqueue 0x0005 -> slot 0.
REQ-031 SHALL cover: MUST_TAKEN_ALL=1 with count=3 -> enqueue_rdy_o=0; MUST_TAKEN_ALL=0 -> enqueue_rdy_o=2'b01.
REQ-032 SHALL cover: patch slot 1 with 2'b11 while holding 0x0002 -> next cycle entry=0xC002; patch an invalid slot -> storage unchanged.
REQ-033 SHALL cover: patch 2'b10 to a slot being enqueued with 0x3FFF -> stored 0xBFFF; patch to the head while dequeuing -> dropped.
REQ-034 SHALL cover: flush with count=3 plus same-cycle enqueue -> next cycle count_o=0, payload_vld_o=0, dequeue_vld_o=0.
